// File: rtl/vga_pixel_unpacker.sv
// Unpacks 128-bit FIFO words into four RGB888 pixels, one per pixel_req, keeping
// frame/word alignment across underflows and reporting starvation and sync errors.
module vga_pixel_unpacker #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024
) (
    input  logic         vga_clk,
    input  logic         vga_reset,
    input  logic         data_fifo_empty,
    input  logic [127:0] data_fifo_rd_data,
    output logic         vga_rd_valid,
    input  logic         frame_start,
    input  logic         pixel_req,
    input  logic         clr_status,
    output logic         pixel_valid,
    output logic [7:0]   pixel_r,
    output logic [7:0]   pixel_g,
    output logic [7:0]   pixel_b,
    output logic         underflow,
    output logic         sync_err,
    output logic [15:0]  underflow_count
);
    localparam int TOTAL_PIX   = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int TOTAL_WORDS = TOTAL_PIX / 4;
    localparam int PIX_W       = $clog2(TOTAL_PIX + 1);
    localparam int WORD_W      = $clog2(TOTAL_WORDS + 1);
    localparam logic [PIX_W-1:0]  LAST_PIX    = PIX_W'(TOTAL_PIX - 1);
    localparam logic [WORD_W-1:0] FRAME_WORDS = WORD_W'(TOTAL_WORDS);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [127:0]        word_q, word_d;
    logic                word_valid_q, word_valid_d;
    logic [1:0]          lane_q, lane_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic [23:0]         rgb_q, rgb_d;
    logic                underflow_q, underflow_d;
    logic                sync_err_q, sync_err_d;
    logic [15:0]         underflow_count_q, underflow_count_d;
    logic                pop_req;
    logic                uf_event;
    logic [23:0]         lane_rgb [4];

    // Byte [31:24] of each lane is padding and never reaches the output.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_rgb[gi] = word_q[32*gi +: 24];
        end
    endgenerate

    always_comb begin
        state_d           = state_q;
        word_d            = word_q;
        word_valid_d      = word_valid_q;
        lane_d            = lane_q;
        pix_cnt_d         = pix_cnt_q;
        word_cnt_d        = word_cnt_q;
        pixel_valid_d     = pixel_req;
        rgb_d             = 24'd0;
        underflow_d       = underflow_q;
        sync_err_d        = sync_err_q;
        underflow_count_d = underflow_count_q;
        pop_req           = 1'b0;
        uf_event          = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d      = PRIME;
                    pix_cnt_d    = '0;
                    word_cnt_d   = '0;
                    word_valid_d = 1'b0;
                    lane_d       = 2'd0;
                end
            end
            PRIME: begin
                if (pixel_req) begin
                    uf_event = 1'b1;
                    state_d  = DRAIN;
                    if (!data_fifo_empty) begin
                        pop_req    = 1'b1;
                        word_cnt_d = word_cnt_q + WORD_W'(1);
                    end
                end else if (!data_fifo_empty) begin
                    pop_req      = 1'b1;
                    word_d       = data_fifo_rd_data;
                    word_valid_d = 1'b1;
                    lane_d       = 2'd0;
                    word_cnt_d   = word_cnt_q + WORD_W'(1);
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (pixel_req) begin
                    if (word_valid_q) begin
                        rgb_d     = lane_rgb[lane_q];
                        lane_d    = lane_q + 2'd1;
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        if (pix_cnt_q == LAST_PIX) begin
                            state_d      = IDLE;
                            word_valid_d = 1'b0;
                        end else if (lane_q == 2'd3) begin
                            // Reload on the consuming cycle so back-to-back pixels never stall.
                            if (!data_fifo_empty) begin
                                pop_req    = 1'b1;
                                word_d     = data_fifo_rd_data;
                                word_cnt_d = word_cnt_q + WORD_W'(1);
                            end else begin
                                word_valid_d = 1'b0;
                            end
                        end
                    end else begin
                        uf_event = 1'b1;
                        state_d  = DRAIN;
                        if (!data_fifo_empty) begin
                            pop_req    = 1'b1;
                            word_cnt_d = word_cnt_q + WORD_W'(1);
                        end
                    end
                end else if (!word_valid_q && !data_fifo_empty) begin
                    pop_req      = 1'b1;
                    word_d       = data_fifo_rd_data;
                    word_valid_d = 1'b1;
                    lane_d       = 2'd0;
                    word_cnt_d   = word_cnt_q + WORD_W'(1);
                end
            end
            DRAIN: begin
                uf_event = pixel_req;
                if (!data_fifo_empty && (word_cnt_q < FRAME_WORDS)) begin
                    pop_req    = 1'b1;
                    word_cnt_d = word_cnt_q + WORD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Leave DRAIN as soon as the last word of the frame has been discarded.
        if ((state_d == DRAIN) && (word_cnt_d == FRAME_WORDS)) begin
            state_d = IDLE;
        end

        if (frame_start && (state_q != IDLE)) begin
            sync_err_d = 1'b1;
        end
        if (uf_event) begin
            underflow_d = 1'b1;
            if (underflow_count_q != 16'hFFFF) begin
                underflow_count_d = underflow_count_q + 16'd1;
            end
        end
        if (clr_status) begin
            underflow_d       = 1'b0;
            sync_err_d        = 1'b0;
            underflow_count_d = 16'd0;
        end
    end

    always_ff @(posedge vga_clk or posedge vga_reset) begin
        if (vga_reset) begin
            state_q           <= IDLE;
            word_q            <= '0;
            word_valid_q      <= 1'b0;
            lane_q            <= 2'd0;
            pix_cnt_q         <= '0;
            word_cnt_q        <= '0;
            pixel_valid_q     <= 1'b0;
            rgb_q             <= 24'd0;
            underflow_q       <= 1'b0;
            sync_err_q        <= 1'b0;
            underflow_count_q <= 16'd0;
        end else begin
            state_q           <= state_d;
            word_q            <= word_d;
            word_valid_q      <= word_valid_d;
            lane_q            <= lane_d;
            pix_cnt_q         <= pix_cnt_d;
            word_cnt_q        <= word_cnt_d;
            pixel_valid_q     <= pixel_valid_d;
            rgb_q             <= rgb_d;
            underflow_q       <= underflow_d;
            sync_err_q        <= sync_err_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    // pop_req already implies !data_fifo_empty; reset gates it without waiting for a clock.
    assign vga_rd_valid    = pop_req && !vga_reset;
    assign pixel_valid     = pixel_valid_q;
    assign pixel_r         = rgb_q[23:16];
    assign pixel_g         = rgb_q[15:8];
    assign pixel_b         = rgb_q[7:0];
    assign underflow       = underflow_q;
    assign sync_err        = sync_err_q;
    assign underflow_count = underflow_count_q;

endmodule

// File: tb/tb_vga_pixel_unpacker.sv
// Directed bench for vga_pixel_unpacker on an 8x2 frame with a queue-modelled FWFT FIFO.
module tb_vga_pixel_unpacker;
    logic         vga_clk;
    logic         vga_reset;
    logic         data_fifo_empty;
    logic [127:0] data_fifo_rd_data;
    logic         vga_rd_valid;
    logic         frame_start;
    logic         pixel_req;
    logic         clr_status;
    logic         pixel_valid;
    logic [7:0]   pixel_r;
    logic [7:0]   pixel_g;
    logic [7:0]   pixel_b;
    logic         underflow;
    logic         sync_err;
    logic [15:0]  underflow_count;

    int           total = 0;
    int           bad   = 0;
    int           pop_cnt = 0;
    logic [127:0] fifo [$];
    logic [23:0]  t2_exp [4];
    logic [127:0] t2_word;

    vga_pixel_unpacker #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2)) dut (
        .vga_clk           (vga_clk),
        .vga_reset         (vga_reset),
        .data_fifo_empty   (data_fifo_empty),
        .data_fifo_rd_data (data_fifo_rd_data),
        .vga_rd_valid      (vga_rd_valid),
        .frame_start       (frame_start),
        .pixel_req         (pixel_req),
        .clr_status        (clr_status),
        .pixel_valid       (pixel_valid),
        .pixel_r           (pixel_r),
        .pixel_g           (pixel_g),
        .pixel_b           (pixel_b),
        .underflow         (underflow),
        .sync_err          (sync_err),
        .underflow_count   (underflow_count)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pc(input int f, input int p);
        return {8'(f * 16 + p), 8'(8'h80 + p), 8'(8'hF0 - p)};
    endfunction

    function automatic logic [127:0] make_word(input int f, input int k);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[32*i +: 32] = {8'hA5, pc(f, 4 * k + i)};
        return w;
    endfunction

    task automatic fifo_refresh();
        data_fifo_empty   = (fifo.size() == 0);
        data_fifo_rd_data = (fifo.size() == 0) ? '0 : fifo[0];
    endtask

    task automatic push(input logic [127:0] w);
        fifo.push_back(w);
        fifo_refresh();
    endtask

    // Called just after a negedge; returns at the next negedge with the FIFO model updated.
    task automatic tick();
        logic pop_now;
        #2;
        pop_now = vga_rd_valid;
        @(posedge vga_clk);
        #1;
        if (pop_now && fifo.size() > 0) begin
            fifo.delete(0);
            pop_cnt++;
        end
        fifo_refresh();
        @(negedge vga_clk);
    endtask

    task automatic serve(input string tag, input int f, input int first, input int count, input bit black);
        pixel_req = 1'b1;
        for (int i = 0; i < count; i++) begin
            tick();
            chk($sformatf("%s_p%0d_valid", tag, first + i), 32'(pixel_valid), 32'd1);
            chk($sformatf("%s_p%0d_rgb", tag, first + i), {8'h00, pixel_r, pixel_g, pixel_b},
                black ? 32'd0 : {8'h00, pc(f, first + i)});
        end
        pixel_req = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic full_frame(input string tag, input int f);
        pop_cnt = 0;
        for (int k = 0; k < 4; k++) push(make_word(f, k));
        start_frame();
        serve(tag, f, 0, 16, 1'b0);
        chk({tag, "_pops"}, 32'(pop_cnt), 32'd4);
        chk({tag, "_fifo_empty"}, 32'(data_fifo_empty), 32'd1);
    endtask

    initial begin
        vga_reset   = 1'b1;
        frame_start = 1'b0;
        pixel_req   = 1'b0;
        clr_status  = 1'b0;
        fifo_refresh();
        t2_exp[0] = 24'h112233;
        t2_exp[1] = 24'h445566;
        t2_exp[2] = 24'hAABBCC;
        t2_exp[3] = 24'hDDEEFF;
        t2_word   = 128'h00DDEEFF_00AABBCC_00445566_00112233;
        @(negedge vga_clk);
        @(negedge vga_clk);

        // Reset state
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("rst_rgb", {8'h00, pixel_r, pixel_g, pixel_b}, 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_count", 32'(underflow_count), 32'd0);
        vga_reset = 1'b0;
        for (int k = 0; k < 4; k++) push(make_word(1, k));
        tick();
        chk("idle_no_pop", 32'(vga_rd_valid), 32'd0);
        chk("idle_pops", 32'(pop_cnt), 32'd0);

        // T1: full clean frame
        start_frame();
        chk("T1_prime_pops", 32'(pop_cnt), 32'd1);
        serve("T1", 1, 0, 16, 1'b0);
        chk("T1_pops", 32'(pop_cnt), 32'd4);
        chk("T1_underflow", 32'(underflow), 32'd0);
        // IDLE: black pixel without an underflow
        push(make_word(9, 0));
        serve("T1_idle", 0, 0, 1, 1'b1);
        tick();
        chk("T1_idle_underflow", 32'(underflow), 32'd0);
        chk("T1_idle_no_pop", 32'(pop_cnt), 32'd4);
        fifo.delete();
        fifo_refresh();

        // T2 lane order, then T4 frame_start mid-RUN
        pop_cnt = 0;
        push(t2_word);
        for (int k = 1; k < 4; k++) push(make_word(2, k));
        start_frame();
        pixel_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("T2_lane%0d_valid", i), 32'(pixel_valid), 32'd1);
            chk($sformatf("T2_lane%0d_rgb", i), {8'h00, pixel_r, pixel_g, pixel_b}, {8'h00, t2_exp[i]});
        end
        pixel_req = 1'b0;
        tick();
        chk("T2_gap_valid", 32'(pixel_valid), 32'd0);
        chk("T2_gap_rgb", {8'h00, pixel_r, pixel_g, pixel_b}, 32'd0);
        serve("T4", 2, 4, 2, 1'b0);
        chk("T4_sync_before", 32'(sync_err), 32'd0);
        frame_start = 1'b1;
        serve("T4", 2, 6, 1, 1'b0);
        frame_start = 1'b0;
        chk("T4_sync_err", 32'(sync_err), 32'd1);
        serve("T4", 2, 7, 9, 1'b0);
        chk("T4_pops", 32'(pop_cnt), 32'd4);
        chk("T4_underflow", 32'(underflow), 32'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("T4_sync_cleared", 32'(sync_err), 32'd0);

        // T3: starved frame, then drain and a clean frame
        pop_cnt = 0;
        push(make_word(3, 0));
        push(make_word(3, 1));
        start_frame();
        serve("T3", 3, 0, 8, 1'b0);
        serve("T3_black", 3, 8, 8, 1'b1);
        chk("T3_underflow", 32'(underflow), 32'd1);
        chk("T3_count", 32'(underflow_count), 32'd8);
        chk("T3_pops_starved", 32'(pop_cnt), 32'd2);
        push(make_word(3, 2));
        push(make_word(3, 3));
        tick();
        tick();
        tick();
        chk("T3_drain_pops", 32'(pop_cnt), 32'd4);
        chk("T3_drain_empty", 32'(data_fifo_empty), 32'd1);
        full_frame("T3_next", 4);
        chk("T3_next_count", 32'(underflow_count), 32'd8);

        // T5: reset while RUN wants to pop
        pop_cnt = 0;
        push(make_word(5, 0));
        start_frame();
        serve("T5", 5, 0, 4, 1'b0);
        push(make_word(5, 1));
        #1;
        chk("T5_pop_pending", 32'(vga_rd_valid), 32'd1);
        vga_reset = 1'b1;
        #1;
        chk("T5_rst_rd_valid", 32'(vga_rd_valid), 32'd0);
        chk("T5_rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("T5_rst_rgb", {8'h00, pixel_r, pixel_g, pixel_b}, 32'd0);
        chk("T5_rst_underflow", 32'(underflow), 32'd0);
        chk("T5_rst_count", 32'(underflow_count), 32'd0);
        tick();
        chk("T5_rst_pops", 32'(pop_cnt), 32'd1);
        vga_reset = 1'b0;
        fifo.delete();
        fifo_refresh();
        tick();
        full_frame("T5_after", 6);
        chk("T5_after_underflow", 32'(underflow), 32'd0);

        // T6: counter saturation and clear priority
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        force dut.underflow_count_d = 16'hFFFE;
        tick();
        release dut.underflow_count_d;
        serve("T6_a", 0, 0, 1, 1'b1);
        chk("T6_count_ffff", 32'(underflow_count), 32'h0000FFFF);
        serve("T6_b", 0, 1, 1, 1'b1);
        chk("T6_count_sat1", 32'(underflow_count), 32'h0000FFFF);
        frame_start = 1'b1;
        serve("T6_c", 0, 2, 1, 1'b1);
        frame_start = 1'b0;
        chk("T6_count_sat2", 32'(underflow_count), 32'h0000FFFF);
        chk("T6_underflow", 32'(underflow), 32'd1);
        chk("T6_sync_err", 32'(sync_err), 32'd1);
        clr_status = 1'b1;
        serve("T6_clr", 0, 3, 1, 1'b1);
        clr_status = 1'b0;
        chk("T6_clr_count", 32'(underflow_count), 32'd0);
        chk("T6_clr_underflow", 32'(underflow), 32'd0);
        chk("T6_clr_sync_err", 32'(sync_err), 32'd0);
        serve("T6_post", 0, 4, 1, 1'b1);
        chk("T6_post_count", 32'(underflow_count), 32'd1);
        chk("T6_post_underflow", 32'(underflow), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
